prog_uart_tx: RTL and testbench

Byte-oriented UART transmitter (8N1, LSB first) that is the transmit-side counterpart of the programming-port `uart_receiver`. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them back to the host. Typical payloads are ICCM-load acknowledgements, echoes, and status bytes. The bit period is set at run time in clock cycles, the same way the receiver's is, so one `clks_per_bit` value serves both directions.

---
 rtl/prog_uart_pkg.sv | 27 ++
 rtl/prog_uart_tx_fifo.sv | 62 ++++++
 rtl/prog_uart_tx.sv | 143 ++++++++++++++
 tb/tb_prog_uart_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/prog_uart_pkg.sv
// ============================================================================
// prog_uart_pkg : shared types and constants for the programming-port UART
// Revision      : 1.0
// ============================================================================
`default_nettype none

package prog_uart_pkg;

  typedef enum logic [1:0] {
    TxIdle  = 2'd0,
    TxStart = 2'd1,
    TxData  = 2'd2,
    TxStop  = 2'd3
  } tx_state_e;

  localparam int unsigned MinClksPerBit = 2;
  localparam int unsigned DataBits      = 8;
  localparam int unsigned FrameBits     = 10;

  // A one-cycle bit would leave the down-counter no room to reload, so clamp.
  function automatic logic [15:0] clamp_period(input logic [15:0] p);
    return (p < 16'(MinClksPerBit)) ? 16'(MinClksPerBit) : p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_uart_tx_fifo.sv
// ============================================================================
// prog_uart_tx_fifo : synchronous byte FIFO, power-of-two depth
// Revision          : 1.0
// ============================================================================
`default_nettype none

module prog_uart_tx_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (r_count == FullCount);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/prog_uart_tx.sv
// ============================================================================
// prog_uart_tx : 8N1 UART transmitter with byte FIFO and run-time bit period
// Revision     : 1.0
// ============================================================================
`default_nettype none

module prog_uart_tx
  import prog_uart_pkg::*;
#(
  parameter int FifoDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] clks_per_bit_i,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_byte_i,
  output logic        tx_ready_o,
  output logic        tx_serial_o,
  output logic        tx_active_o,
  output logic        tx_done_o
);

  localparam int CntW = $clog2(FifoDepth) + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);

  tx_state_e       r_state;
  logic [15:0]     r_timer;
  logic [15:0]     r_period;
  logic [7:0]      r_byte;
  logic [2:0]      r_idx;
  logic            r_serial;
  logic            r_active;
  logic            r_done;

  logic [7:0]      w_fifo_data;
  logic            w_full;
  logic            w_empty;
  logic [CntW-1:0] w_count;
  logic            w_push;
  logic            w_pop;
  logic            w_bit_end;
  logic [15:0]     w_load_period;

  assign tx_ready_o    = (w_count != FullCount);
  assign w_push        = tx_valid_i && !w_full;
  assign w_bit_end     = (r_timer == 16'd0);
  assign w_load_period = clamp_period(clks_per_bit_i);
  // Pop either from idle or exactly at the end of a stop bit for gapless frames.
  assign w_pop = !w_empty &&
                 ((r_state == TxIdle) || ((r_state == TxStop) && w_bit_end));

  prog_uart_tx_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (tx_byte_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= TxIdle;
      r_timer  <= '0;
      r_period <= 16'(MinClksPerBit);
      r_byte   <= '0;
      r_idx    <= '0;
      r_serial <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        TxIdle: begin
          if (w_pop) begin
            r_byte   <= w_fifo_data;
            r_period <= w_load_period;
            r_timer  <= w_load_period - 16'd1;
            r_serial <= 1'b0;
            r_active <= 1'b1;
            r_state  <= TxStart;
          end
        end
        TxStart: begin
          if (w_bit_end) begin
            r_idx    <= '0;
            r_serial <= r_byte[0];
            r_timer  <= r_period - 16'd1;
            r_state  <= TxData;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        TxData: begin
          if (w_bit_end) begin
            r_timer <= r_period - 16'd1;
            if (r_idx == 3'(DataBits - 1)) begin
              r_serial <= 1'b1;
              r_state  <= TxStop;
            end else begin
              r_idx    <= r_idx + 3'd1;
              r_serial <= r_byte[r_idx + 3'd1];
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        TxStop: begin
          if (w_bit_end) begin
            r_done <= 1'b1;
            if (w_pop) begin
              r_byte   <= w_fifo_data;
              r_period <= w_load_period;
              r_timer  <= w_load_period - 16'd1;
              r_serial <= 1'b0;
              r_state  <= TxStart;
            end else begin
              r_serial <= 1'b1;
              r_active <= 1'b0;
              r_state  <= TxIdle;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= TxIdle;
      endcase
    end
  end

  assign tx_serial_o = r_serial;
  assign tx_active_o = r_active;
  assign tx_done_o   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_prog_uart_tx.sv
// ============================================================================
// tb_prog_uart_tx : directed self-checking bench for prog_uart_tx
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_prog_uart_tx;

  logic        clk;
  logic        rst;
  logic [15:0] clks_per_bit;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        tx_serial;
  logic        tx_active;
  logic        tx_done;

  int n_vec = 0;
  int n_err = 0;

  prog_uart_tx #(
    .FifoDepth (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clks_per_bit_i (clks_per_bit),
    .tx_valid_i     (tx_valid),
    .tx_byte_i      (tx_byte),
    .tx_ready_o     (tx_ready),
    .tx_serial_o    (tx_serial),
    .tx_active_o    (tx_active),
    .tx_done_o      (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_byte  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  // Called with the current sample at cycle k0 of a frame (k=0 is the first start cycle).
  task automatic check_frame(input logic [7:0] b, input int p, input int k0,
                             input int chg_at, input logic [15:0] chg_val);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = k0; k < 10 * p; k++) begin
      if (k == chg_at) clks_per_bit = chg_val;
      chk("serial", tx_serial, fr[k / p]);
      chk("active", tx_active, 1);
      if (k > 0) chk("done_low", tx_done, 0);
      tick();
    end
  endtask

  task automatic check_idle_after_done();
    chk("done_pulse", tx_done, 1);
    tick();
    chk("idle_serial", tx_serial, 1);
    chk("idle_active", tx_active, 0);
    chk("idle_done", tx_done, 0);
  endtask

  task automatic run_single(input logic [7:0] b, input int p);
    push(b);
    chk("pre_start_serial", tx_serial, 1);
    chk("pre_start_active", tx_active, 0);
    tick();
    check_frame(b, p, 0, -1, 16'd0);
    check_idle_after_done();
  endtask

  initial begin
    rst          = 1'b0;
    clks_per_bit = 16'd4;
    tx_valid     = 1'b0;
    tx_byte      = 8'h00;
    #1 rst = 1'b1;
    #2;
    chk("rst_serial", tx_serial, 1);
    chk("rst_active", tx_active, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ready", tx_ready, 1);

    // Pushes during reset must not be queued.
    tx_valid = 1'b1;
    tx_byte  = 8'h99;
    tick();
    tick();
    rst      = 1'b0;
    tx_valid = 1'b0;
    tick();
    tick();
    chk("rst_push_serial", tx_serial, 1);
    chk("rst_push_active", tx_active, 0);

    // Single frame at P=4
    clks_per_bit = 16'd4;
    run_single(8'hA5, 4);

    // Five back-to-back frames; a sixth push attempted while full is dropped.
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    push(8'hAA);
    push(8'h0F);
    chk("ready_full", tx_ready, 0);
    tx_valid = 1'b1;
    tx_byte  = 8'hEE;
    check_frame(8'h00, 4, 3, -1, 16'd0);
    tx_valid = 1'b0;
    chk("done_f1", tx_done, 1);
    chk("ready_refill", tx_ready, 1);
    check_frame(8'hFF, 4, 0, -1, 16'd0);
    chk("done_f2", tx_done, 1);
    check_frame(8'h55, 4, 0, -1, 16'd0);
    chk("done_f3", tx_done, 1);
    check_frame(8'hAA, 4, 0, -1, 16'd0);
    chk("done_f4", tx_done, 1);
    check_frame(8'h0F, 4, 0, -1, 16'd0);
    check_idle_after_done();
    tick();
    chk("no_sixth_frame", tx_serial, 1);

    // Clamp of degenerate periods
    clks_per_bit = 16'd0;
    run_single(8'h5A, 2);
    clks_per_bit = 16'd1;
    run_single(8'hC3, 2);

    // Period change during data bit 2 only affects the next frame
    clks_per_bit = 16'd4;
    push(8'h81);
    push(8'h7E);
    check_frame(8'h81, 4, 0, 12, 16'd8);
    chk("done_chg1", tx_done, 1);
    check_frame(8'h7E, 8, 0, -1, 16'd0);
    check_idle_after_done();

    // Reset mid-frame during data bit 3 with two bytes queued
    clks_per_bit = 16'd4;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (16) tick();
    chk("pre_rst_bit3", tx_serial, 0);
    chk("pre_rst_active", tx_active, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_serial", tx_serial, 1);
    chk("midrst_active", tx_active, 0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_done", tx_done, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_serial", tx_serial, 1);
      chk("postrst_active", tx_active, 0);
      chk("postrst_done", tx_done, 0);
    end
    run_single(8'h3C, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
